// File: rtl/reg_scoreboard_pkg.sv
// Shared types and sizing for the register scoreboard: register indexing,
// counter width and the issue-control FSM states.
package reg_scoreboard_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;
  localparam int CNT_W     = 2;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } sb_state_e;

  function automatic logic [NUM_REGS-1:0] idx_onehot(input reg_idx_t idx);
    idx_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/write-back side bundle of the scoreboard; master drives requests,
// slave is the scoreboard itself.
interface reg_scoreboard_if;
  import reg_scoreboard_pkg::*;

  logic                issue_valid;
  reg_idx_t            issue_rs1;
  reg_idx_t            issue_rs2;
  logic                issue_use_rs1;
  logic                issue_use_rs2;
  logic                issue_rw;
  reg_idx_t            issue_rd;
  logic                wb_valid;
  reg_idx_t            wb_rd;
  logic                flush;
  logic                stall;
  logic                issue_fire;
  logic [NUM_REGS-1:0] busy_mask;
  logic                draining;
  logic                err_underflow;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_rw, issue_rd, wb_valid, wb_rd, flush,
    input  stall, issue_fire, busy_mask, draining, err_underflow
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
           issue_rw, issue_rd, wb_valid, wb_rd, flush,
    output stall, issue_fire, busy_mask, draining, err_underflow
  );

endinterface

// File: rtl/reg_scoreboard_sb_counter.sv
// One in-flight write counter: saturating up/down with clear, exposing zero,
// max and the zero-ness of the value about to be loaded.
module sb_counter
  import reg_scoreboard_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic max,
  output logic next_zero
);

  localparam logic [W-1:0] ZERO_VAL = {W{1'b0}};
  localparam logic [W-1:0] ONE_VAL  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] MAX_VAL  = {W{1'b1}};

  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_next_s;

  // Next count; simultaneous inc and dec cancel, ends never wrap
  always_comb begin
    cnt_next_s = cnt_r;
    if (clear) begin
      cnt_next_s = ZERO_VAL;
    end else if (inc && !dec && (cnt_r != MAX_VAL)) begin
      cnt_next_s = cnt_r + ONE_VAL;
    end else if (dec && !inc && (cnt_r != ZERO_VAL)) begin
      cnt_next_s = cnt_r - ONE_VAL;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= ZERO_VAL;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  assign zero      = (cnt_r == ZERO_VAL);
  assign max       = (cnt_r == MAX_VAL);
  assign next_zero = (cnt_next_s == ZERO_VAL);

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side scoreboard: per-register in-flight counters, RAW/saturation stall
// and a post-flush drain before issue re-opens.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter bit X0_HARDWIRED = 1'b1
) (
  input logic              clk,
  input logic              reset,
  reg_scoreboard_if.slave  sb
);

  localparam logic [NUM_REGS-1:0] TRACK_MASK =
    X0_HARDWIRED ? ~{{(NUM_REGS-1){1'b0}}, 1'b1} : {NUM_REGS{1'b1}};

  sb_state_e           state_r;
  sb_state_e           state_next_s;
  logic                err_r;
  logic [NUM_REGS-1:0] zero_s;
  logic [NUM_REGS-1:0] max_s;
  logic [NUM_REGS-1:0] next_zero_s;
  logic [NUM_REGS-1:0] inc_s;
  logic [NUM_REGS-1:0] dec_s;
  logic                draining_s;
  logic                stall_s;
  logic                fire_s;
  logic                underflow_s;

  // Register 0 is held at zero when hardwired, so it never reads busy
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cnt
    sb_counter #(.W(CNT_W)) u_cnt (
      .clk       (clk),
      .reset     (reset),
      .clear     (X0_HARDWIRED && (i == 0)),
      .inc       (inc_s[i]),
      .dec       (dec_s[i]),
      .zero      (zero_s[i]),
      .max       (max_s[i]),
      .next_zero (next_zero_s[i])
    );
  end

  // Hazard, fire and per-register update terms from registered counts only
  always_comb begin
    draining_s  = (state_r == ST_DRAIN);
    stall_s     = sb.issue_valid &&
                  (draining_s ||
                   (sb.issue_use_rs1 && !zero_s[sb.issue_rs1]) ||
                   (sb.issue_use_rs2 && !zero_s[sb.issue_rs2]) ||
                   (sb.issue_rw && max_s[sb.issue_rd]));
    fire_s      = sb.issue_valid && !stall_s;
    inc_s       = {NUM_REGS{1'b0}};
    dec_s       = {NUM_REGS{1'b0}};
    underflow_s = 1'b0;
    if (fire_s && sb.issue_rw) begin
      inc_s = idx_onehot(sb.issue_rd) & TRACK_MASK;
    end else begin
      inc_s = {NUM_REGS{1'b0}};
    end
    if (sb.wb_valid) begin
      dec_s       = idx_onehot(sb.wb_rd) & ~zero_s;
      underflow_s = zero_s[sb.wb_rd] && !(X0_HARDWIRED && (sb.wb_rd == 5'd0));
    end else begin
      dec_s       = {NUM_REGS{1'b0}};
      underflow_s = 1'b0;
    end
  end

  // Next-state logic; drain exits once every counter is about to be zero
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (sb.flush) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (sb.flush) begin
          state_next_s = ST_DRAIN;
        end else if (&next_zero_s) begin
          state_next_s = ST_RUN;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // FSM state and sticky underflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_RUN;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_next_s;
      err_r   <= err_r | underflow_s;
    end
  end

  assign sb.stall         = stall_s;
  assign sb.issue_fire    = fire_s;
  assign sb.busy_mask     = ~zero_s;
  assign sb.draining      = draining_s;
  assign sb.err_underflow = err_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: one task per scenario, inline checks
// against hand-computed values.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  reg_scoreboard_if bus ();

  reg_scoreboard #(.X0_HARDWIRED(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; checks sample at +3.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.issue_valid   = 1'b0;
    bus.issue_rs1     = 5'd0;
    bus.issue_rs2     = 5'd0;
    bus.issue_use_rs1 = 1'b0;
    bus.issue_use_rs2 = 1'b0;
    bus.issue_rw      = 1'b0;
    bus.issue_rd      = 5'd0;
    bus.wb_valid      = 1'b0;
    bus.wb_rd         = 5'd0;
    bus.flush         = 1'b0;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    idle();
    bus.issue_valid = 1'b1;
    bus.issue_rw    = 1'b1;
    bus.issue_rd    = rd;
  endtask

  task automatic issue_rd1(input logic [4:0] rs);
    idle();
    bus.issue_valid   = 1'b1;
    bus.issue_use_rs1 = 1'b1;
    bus.issue_rs1     = rs;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    #1;
    total_cnt++; if (bus.busy_mask !== 32'h0) $display("FAIL reset_busy got %h exp %h", bus.busy_mask, 32'h0); else pass_cnt++;
    total_cnt++; if (bus.draining !== 1'b0) $display("FAIL reset_draining got %b exp 0", bus.draining); else pass_cnt++;
    total_cnt++; if (bus.err_underflow !== 1'b0) $display("FAIL reset_err got %b exp 0", bus.err_underflow); else pass_cnt++;
    total_cnt++; if (bus.stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", bus.stall); else pass_cnt++;
    total_cnt++; if (bus.issue_fire !== 1'b0) $display("FAIL reset_fire got %b exp 0", bus.issue_fire); else pass_cnt++;
  endtask

  task automatic test_raw();
    tick();
    issue_wr(5'd5);
    #1;
    total_cnt++; if (bus.issue_fire !== 1'b1) $display("FAIL raw_first_fire got %b exp 1", bus.issue_fire); else pass_cnt++;
    tick();
    issue_rd1(5'd5);
    #1;
    total_cnt++; if (bus.stall !== 1'b1) $display("FAIL raw_stall got %b exp 1", bus.stall); else pass_cnt++;
    total_cnt++; if (bus.busy_mask !== 32'h0000_0020) $display("FAIL raw_busy got %h exp %h", bus.busy_mask, 32'h0000_0020); else pass_cnt++;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd5;
    #1;
    total_cnt++; if (bus.stall !== 1'b1) $display("FAIL raw_stall_same_cycle_wb got %b exp 1", bus.stall); else pass_cnt++;
    tick();
    bus.wb_valid = 1'b0;
    #1;
    total_cnt++; if (bus.stall !== 1'b0) $display("FAIL raw_release got %b exp 0", bus.stall); else pass_cnt++;
    total_cnt++; if (bus.issue_fire !== 1'b1) $display("FAIL raw_release_fire got %b exp 1", bus.issue_fire); else pass_cnt++;
    total_cnt++; if (bus.busy_mask !== 32'h0) $display("FAIL raw_busy_clear got %h exp %h", bus.busy_mask, 32'h0); else pass_cnt++;
    tick();
    idle();
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      issue_wr(5'd7);
      tick();
    end
    idle();
    #1;
    total_cnt++; if (bus.busy_mask !== 32'h0000_0080) $display("FAIL sat_busy got %h exp %h", bus.busy_mask, 32'h0000_0080); else pass_cnt++;
    issue_wr(5'd7);
    #1;
    total_cnt++; if (bus.stall !== 1'b1) $display("FAIL sat_stall got %b exp 1", bus.stall); else pass_cnt++;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd7;
    #1;
    total_cnt++; if (bus.issue_fire !== 1'b0) $display("FAIL sat_fire_same_cycle_wb got %b exp 0", bus.issue_fire); else pass_cnt++;
    tick();
    bus.wb_valid = 1'b0;
    #1;
    total_cnt++; if (bus.issue_fire !== 1'b1) $display("FAIL sat_fire_after_wb got %b exp 1", bus.issue_fire); else pass_cnt++;
    tick();
    for (int k = 0; k < 3; k++) begin
      idle();
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 5'd7;
      tick();
    end
    idle();
    #1;
    total_cnt++; if (bus.busy_mask !== 32'h0) $display("FAIL sat_drained got %h exp %h", bus.busy_mask, 32'h0); else pass_cnt++;
  endtask

  task automatic test_same_cycle();
    issue_wr(5'd9);
    tick();
    issue_wr(5'd9);
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd9;
    #1;
    total_cnt++; if (bus.issue_fire !== 1'b1) $display("FAIL same_fire got %b exp 1", bus.issue_fire); else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++; if (bus.busy_mask !== 32'h0000_0200) $display("FAIL same_busy got %h exp %h", bus.busy_mask, 32'h0000_0200); else pass_cnt++;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd9;
    tick();
    idle();
    #1;
    total_cnt++; if (bus.busy_mask !== 32'h0) $display("FAIL same_busy_clear got %h exp %h", bus.busy_mask, 32'h0); else pass_cnt++;
    total_cnt++; if (bus.err_underflow !== 1'b0) $display("FAIL same_no_underflow got %b exp 0", bus.err_underflow); else pass_cnt++;
  endtask

  task automatic test_x0_underflow();
    issue_wr(5'd0);
    tick();
    issue_rd1(5'd0);
    #1;
    total_cnt++; if (bus.stall !== 1'b0) $display("FAIL x0_stall got %b exp 0", bus.stall); else pass_cnt++;
    total_cnt++; if (bus.busy_mask !== 32'h0) $display("FAIL x0_busy got %h exp %h", bus.busy_mask, 32'h0); else pass_cnt++;
    idle();
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd0;
    tick();
    idle();
    #1;
    total_cnt++; if (bus.err_underflow !== 1'b0) $display("FAIL x0_wb_silent got %b exp 0", bus.err_underflow); else pass_cnt++;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd4;
    tick();
    idle();
    #1;
    total_cnt++; if (bus.err_underflow !== 1'b1) $display("FAIL underflow_set got %b exp 1", bus.err_underflow); else pass_cnt++;
    tick();
    tick();
    total_cnt++; if (bus.err_underflow !== 1'b1) $display("FAIL underflow_sticky got %b exp 1", bus.err_underflow); else pass_cnt++;
    total_cnt++; if (bus.busy_mask !== 32'h0) $display("FAIL underflow_no_count got %h exp %h", bus.busy_mask, 32'h0); else pass_cnt++;
  endtask

  task automatic test_flush_drain();
    issue_wr(5'd3);
    tick();
    issue_wr(5'd3);
    tick();
    idle();
    bus.flush = 1'b1;
    tick();
    idle();
    issue_rd1(5'd1);
    #1;
    total_cnt++; if (bus.draining !== 1'b1) $display("FAIL drain_enter got %b exp 1", bus.draining); else pass_cnt++;
    total_cnt++; if (bus.stall !== 1'b1) $display("FAIL drain_stall got %b exp 1", bus.stall); else pass_cnt++;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = 5'd3;
    tick();
    #1;
    total_cnt++; if (bus.draining !== 1'b1) $display("FAIL drain_hold got %b exp 1", bus.draining); else pass_cnt++;
    total_cnt++; if (bus.stall !== 1'b1) $display("FAIL drain_stall2 got %b exp 1", bus.stall); else pass_cnt++;
    tick();
    bus.wb_valid = 1'b0;
    #1;
    total_cnt++; if (bus.draining !== 1'b0) $display("FAIL drain_exit got %b exp 0", bus.draining); else pass_cnt++;
    total_cnt++; if (bus.issue_fire !== 1'b1) $display("FAIL drain_exit_fire got %b exp 1", bus.issue_fire); else pass_cnt++;
    tick();
    idle();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    #1;
    total_cnt++; if (bus.draining !== 1'b1) $display("FAIL empty_drain_enter got %b exp 1", bus.draining); else pass_cnt++;
    tick();
    #1;
    total_cnt++; if (bus.draining !== 1'b0) $display("FAIL empty_drain_one_cycle got %b exp 0", bus.draining); else pass_cnt++;
  endtask

  task automatic test_reset_in_drain();
    issue_wr(5'd12);
    tick();
    issue_wr(5'd12);
    tick();
    idle();
    bus.flush = 1'b1;
    tick();
    idle();
    #1;
    total_cnt++; if (bus.draining !== 1'b1) $display("FAIL rst_drain_pre got %b exp 1", bus.draining); else pass_cnt++;
    total_cnt++; if (bus.busy_mask !== 32'h0000_1000) $display("FAIL rst_drain_busy_pre got %h exp %h", bus.busy_mask, 32'h0000_1000); else pass_cnt++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    issue_rd1(5'd12);
    #1;
    total_cnt++; if (bus.busy_mask !== 32'h0) $display("FAIL rst_drain_busy got %h exp %h", bus.busy_mask, 32'h0); else pass_cnt++;
    total_cnt++; if (bus.draining !== 1'b0) $display("FAIL rst_drain_draining got %b exp 0", bus.draining); else pass_cnt++;
    total_cnt++; if (bus.err_underflow !== 1'b0) $display("FAIL rst_drain_err got %b exp 0", bus.err_underflow); else pass_cnt++;
    total_cnt++; if (bus.issue_fire !== 1'b1) $display("FAIL rst_drain_fire got %b exp 1", bus.issue_fire); else pass_cnt++;
    tick();
    idle();
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    idle();
    test_reset();
    test_raw();
    test_saturation();
    test_same_cycle();
    test_x0_underflow();
    test_flush_drain();
    test_reset_in_drain();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
